main: RTL and testbench
=======================

MAIN -- requirements
Module: main

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state and both RAMs.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 r_enable  in  1  start strobe, sampled in IDLE only.
REQ-005 controlArr  in  1  1 = host owns both RAM ports; 0 = datapath owns them.
REQ-006 init_i  in  64  start index, unsigned.
REQ-007 init_acc  in  64  initial accumulator value.
REQ-008 w_enable  out  1  done pulse; result valid while high.
REQ-009 result  out  64  final accumulator, two's complement.
REQ-010 controlArrWEnable_a / controlArrWEnable_b  in  1  host write enable for RAM a / b.
REQ-011 controlArrAddr_a / controlArrAddr_b  in  10  host address for RAM a / b.
REQ-012 controlArrWData_a / controlArrWData_b  in  27 signed  host write data.
REQ-013 controlArrRData_a / controlArrRData_b  out  27 signed  host read data, registered.

Function
REQ-014 SHALL contain two single-port synchronous RAMs, a and b, each 1024 x 27 bit signed; RAM contents are not reset.
REQ-015 While controlArr=1, each RAM's port SHALL be driven by its host signals: write data to addr at posedge when WEnable=1; RData = mem[addr] one cycle after the address is presented (read-before-write on same-address write).
REQ-016 While controlArr=0, host write enables SHALL be ignored; RAM ports belong to the datapath.
REQ-017 FSM states: IDLE, LOAD, WAIT, MAC, DONE.
REQ-018 IDLE: when r_enable=1 and controlArr=0 at posedge, latch i<=init_i and acc<=init_acc; go to LOAD if init_i<1000, else DONE.
REQ-019 r_enable while controlArr=1 SHALL be ignored.
REQ-020 LOAD: drive address i[9:0] to both RAMs; go to WAIT.
REQ-021 WAIT: RAM data becomes valid; go to MAC.
REQ-022 MAC, arithmetic: acc <= acc + sign_extend64(a[i]*b[i]); the product is a full signed 54-bit value; the sum wraps modulo 2^64 with no saturation.
REQ-023 MAC, loop control: i <= i+1; go to LOAD if i+1<1000, else DONE.
REQ-024 DONE: result <= acc and w_enable=1 for exactly one cycle, aligned so result already holds the final value during that cycle; then return to IDLE.
REQ-025 result SHALL hold its value until the next DONE.
REQ-026 Latency: for N = 1000 - init_i elements (N>0), w_enable asserts 3N+1 cycles after the start edge. For init_i >= 1000, it asserts 1 cycle after the start edge with result = init_acc.
REQ-027 r_enable outside IDLE SHALL be ignored and not queued.
REQ-028 Asserting controlArr while the machine is not in IDLE is illegal; in that case the result value is unspecified.
REQ-029 The FSM SHALL still reach DONE and return to IDLE even if controlArr is asserted mid-run.
REQ-030 Comparisons of i against 1000 SHALL be unsigned 64-bit.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE, w_enable=0, result=0, acc=0, i=0, controlArrRData_a=0 and controlArrRData_b=0.
REQ-032 Reset mid-run SHALL abort the computation with no w_enable pulse.
REQ-033 RAM contents SHALL be preserved across reset.
REQ-034 After rst deasserts, the first posedge SHALL accept r_enable.

Verification
REQ-035 Random load: load 1000 random signed 27-bit pairs via host ports, then controlArr=0 with r_enable=1 for one cycle, init_i=0, init_acc=0 -> single w_enable pulse 3001 cycles later; result equals the 64-bit wrapped sum of the signed products.
REQ-036 Extreme operands: all a = -2^26 and all b = -2^26, init_i=0 -> result = 1000*2^52.
REQ-037 Offset start: a[i]=1, b[i]=i, init_i=990, init_acc=5 -> result = 5 + (990+...+999) = 9950; latency 31 cycles.
REQ-038 Zero iterations: init_i=1000, init_acc=-7 -> w_enable 1 cycle after start; result = -7.
REQ-039 Host read-back: write addr 3 = -1 with controlArr=1, then present addr 3 -> controlArrRData_a = -1 one cycle later.
REQ-040 Reset mid-run: assert rst during MAC -> no w_enable pulse and result=0; a subsequent start completes correctly with unchanged RAM data.

Source files
------------

// File: rtl/main.sv
// Dot-product engine: two 1024x27 signed RAMs, host-loadable, and a MAC loop that
// accumulates a[i]*b[i] for i = init_i .. 999 into a 64-bit wrapping accumulator.
module main (
    input  logic               clk,
    input  logic               rst,
    input  logic               r_enable,
    input  logic               controlArr,
    input  logic [63:0]        init_i,
    input  logic [63:0]        init_acc,
    output logic               w_enable,
    output logic [63:0]        result,
    input  logic               controlArrWEnable_a,
    input  logic               controlArrWEnable_b,
    input  logic [9:0]         controlArrAddr_a,
    input  logic [9:0]         controlArrAddr_b,
    input  logic signed [26:0] controlArrWData_a,
    input  logic signed [26:0] controlArrWData_b,
    output logic signed [26:0] controlArrRData_a,
    output logic signed [26:0] controlArrRData_b
);

    localparam logic [63:0] LastIdx = 64'd1000;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StMac,
        StDone
    } state_e;

    state_e             state_q;
    logic [63:0]        i_q;
    logic [63:0]        acc_q;

    logic signed [26:0] mem_a [1024];
    logic signed [26:0] mem_b [1024];

    logic [9:0]         addr_a;
    logic [9:0]         addr_b;
    logic               we_a;
    logic               we_b;

    logic signed [53:0] op_a;
    logic signed [53:0] op_b;
    logic signed [53:0] prod;
    logic [63:0]        prod_ext;
    logic [63:0]        acc_sum;
    logic [63:0]        i_inc;

    // Host owns the RAM ports only while controlArr is high; otherwise the loop index drives them.
    always_comb begin
        addr_a = controlArr ? controlArrAddr_a : i_q[9:0];
        addr_b = controlArr ? controlArrAddr_b : i_q[9:0];
        we_a   = controlArr & controlArrWEnable_a;
        we_b   = controlArr & controlArrWEnable_b;
    end

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= controlArrWData_a;
        end
    end

    always_ff @(posedge clk) begin
        if (we_b) begin
            mem_b[addr_b] <= controlArrWData_b;
        end
    end

    // Registered read ports double as the datapath operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            controlArrRData_a <= '0;
            controlArrRData_b <= '0;
        end else begin
            controlArrRData_a <= mem_a[addr_a];
            controlArrRData_b <= mem_b[addr_b];
        end
    end

    always_comb begin
        op_a     = 54'(controlArrRData_a);
        op_b     = 54'(controlArrRData_b);
        prod     = op_a * op_b;
        prod_ext = {{10{prod[53]}}, prod};
        acc_sum  = acc_q + prod_ext;
        i_inc    = i_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            i_q      <= '0;
            acc_q    <= '0;
            result   <= '0;
            w_enable <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (r_enable && !controlArr) begin
                        i_q     <= init_i;
                        acc_q   <= init_acc;
                        state_q <= (init_i < LastIdx) ? StLoad : StDone;
                    end
                end
                StLoad: begin
                    state_q <= StWait;
                end
                StWait: begin
                    state_q <= StMac;
                end
                StMac: begin
                    acc_q   <= acc_sum;
                    i_q     <= i_inc;
                    state_q <= (i_inc < LastIdx) ? StLoad : StDone;
                end
                StDone: begin
                    result   <= acc_q;
                    w_enable <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main.sv
// Directed bench for main: host RAM access, MAC results, latency, zero-iteration and reset cases.
`timescale 1ns/1ps
module tb_main;

    logic               clk = 1'b0;
    logic               rst;
    logic               r_enable;
    logic               controlArr;
    logic [63:0]        init_i;
    logic [63:0]        init_acc;
    logic               w_enable;
    logic [63:0]        result;
    logic               controlArrWEnable_a;
    logic               controlArrWEnable_b;
    logic [9:0]         controlArrAddr_a;
    logic [9:0]         controlArrAddr_b;
    logic signed [26:0] controlArrWData_a;
    logic signed [26:0] controlArrWData_b;
    logic signed [26:0] controlArrRData_a;
    logic signed [26:0] controlArrRData_b;

    int n_vec = 0;
    int n_err = 0;

    logic signed [26:0] va [1000];
    logic signed [26:0] vb [1000];

    main dut (
        .clk                 (clk),
        .rst                 (rst),
        .r_enable            (r_enable),
        .controlArr          (controlArr),
        .init_i              (init_i),
        .init_acc            (init_acc),
        .w_enable            (w_enable),
        .result              (result),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrWEnable_b (controlArrWEnable_b),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrAddr_b    (controlArrAddr_b),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrWData_b   (controlArrWData_b),
        .controlArrRData_a   (controlArrRData_a),
        .controlArrRData_b   (controlArrRData_b)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [9:0] addr, input logic signed [26:0] a,
                              input logic signed [26:0] b);
        controlArr          = 1'b1;
        controlArrAddr_a    = addr;
        controlArrAddr_b    = addr;
        controlArrWData_a   = a;
        controlArrWData_b   = b;
        controlArrWEnable_a = 1'b1;
        controlArrWEnable_b = 1'b1;
        tick();
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
    endtask

    // Start a run and count cycles until the done pulse; lat = -1 if it never comes.
    task automatic run(input logic [63:0] ii, input logic [63:0] ia, input int max_cyc,
                       input int poke_at, output int lat);
        controlArr = 1'b0;
        init_i     = ii;
        init_acc   = ia;
        r_enable   = 1'b1;
        tick();
        r_enable   = 1'b0;
        lat        = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            r_enable = (k == poke_at);
            if (w_enable) begin
                lat = k;
                break;
            end
        end
        r_enable = 1'b0;
    endtask

    task automatic check_no_pulse(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (w_enable) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] model;
        longint      p;

        rst                 = 1'b1;
        r_enable            = 1'b0;
        controlArr          = 1'b0;
        init_i              = '0;
        init_acc            = '0;
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
        controlArrAddr_a    = '0;
        controlArrAddr_b    = '0;
        controlArrWData_a   = '0;
        controlArrWData_b   = '0;
        #1;
        tick();
        check("reset_w_enable", 64'(w_enable), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_rdata_a", controlArrRData_a, 64'd0);
        check("reset_rdata_b", controlArrRData_b, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Host read-back, including read-before-write on the same address
        host_write(10'd3, -27'sd1, 27'sd5);
        controlArrAddr_a = 10'd3;
        controlArrAddr_b = 10'd3;
        tick();
        check("host_rd_a", controlArrRData_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("host_rd_b", controlArrRData_b, 64'd5);
        host_write(10'd3, 27'sd7, 27'sd9);
        check("rbw_old_a", controlArrRData_a, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("rbw_new_a", controlArrRData_a, 64'd7);

        // Host write enables must be ignored while the datapath owns the RAMs
        controlArr          = 1'b0;
        controlArrAddr_a    = 10'd3;
        controlArrWData_a   = 27'sd100;
        controlArrWEnable_a = 1'b1;
        tick();
        controlArrWEnable_a = 1'b0;
        controlArr          = 1'b1;
        tick();
        tick();
        check("we_ignored", controlArrRData_a, 64'd7);

        // r_enable while the host owns the RAMs is ignored
        controlArr = 1'b1;
        r_enable   = 1'b1;
        init_i     = 64'd1000;
        tick();
        r_enable   = 1'b0;
        check_no_pulse("host_start_ignored", 6);

        // Random dot product over all 1000 entries
        model = '0;
        for (int k = 0; k < 1000; k++) begin
            va[k] = 27'($urandom);
            vb[k] = 27'($urandom);
            host_write(10'(k), va[k], vb[k]);
            p = longint'(va[k]) * longint'(vb[k]);
            model = model + 64'(p);
        end
        run(64'd0, 64'd0, 4000, 100, lat);
        check("rand_latency", 64'(lat), 64'd3001);
        check("rand_result", result, model);
        tick();
        check("rand_single_pulse", 64'(w_enable), 64'd0);
        check_no_pulse("rand_no_queued", 8);
        check("rand_result_hold", result, model);

        // Extreme operands: (-2^26)^2 * 1000
        for (int k = 0; k < 1000; k++) begin
            host_write(10'(k), -27'sd67108864, -27'sd67108864);
        end
        run(64'd0, 64'd0, 4000, 0, lat);
        check("extreme_latency", 64'(lat), 64'd3001);
        check("extreme_result", result, 64'd1000 << 52);

        // Offset start: a=1, b=i for i in 990..999
        for (int k = 990; k < 1000; k++) begin
            host_write(10'(k), 27'sd1, 27'(k));
        end
        run(64'd990, 64'd5, 100, 0, lat);
        check("offset_latency", 64'(lat), 64'd31);
        check("offset_result", result, 64'd9950);

        // Zero iterations, and an index that is only out of range as unsigned
        run(64'd1000, -64'sd7, 10, 0, lat);
        check("zero_latency", 64'(lat), 64'd1);
        check("zero_result", result, 64'hFFFF_FFFF_FFFF_FFF9);
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 10, 0, lat);
        check("huge_i_latency", 64'(lat), 64'd1);
        check("huge_i_result", result, 64'd42);

        // Reset during MAC aborts the run without a pulse
        controlArr = 1'b0;
        init_i     = 64'd990;
        init_acc   = 64'd5;
        r_enable   = 1'b1;
        tick();
        r_enable   = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        rst = 1'b1;
        #1;
        check("midrst_w_enable", 64'(w_enable), 64'd0);
        check("midrst_result", result, 64'd0);
        tick();
        rst = 1'b0;
        check_no_pulse("midrst_no_pulse", 40);
        check("midrst_result_after", result, 64'd0);

        // Restart right after reset; RAM contents must have survived
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(64'd990, 64'd5, 100, 0, lat);
        check("post_rst_latency", 64'(lat), 64'd31);
        check("post_rst_result", result, 64'd9950);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
